alu_op_sequencer: RTL and testbench

//  Handshaked, multi-cycle ALU front end that drives the bitwise gate-level op modules.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_gates.sv | 57 +++++
 rtl/alu_logic_core.sv | 45 ++++
 rtl/alu_op_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, sequencer state encoding and shift classification for the ALU sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] OP_OR     = 4'd0;
   localparam logic [OP_W-1:0] OP_AND    = 4'd1;
   localparam logic [OP_W-1:0] OP_XOR    = 4'd2;
   localparam logic [OP_W-1:0] OP_NOR    = 4'd3;
   localparam logic [OP_W-1:0] OP_NOT_A  = 4'd4;
   localparam logic [OP_W-1:0] OP_PASS_A = 4'd5;
   localparam logic [OP_W-1:0] OP_PASS_B = 4'd6;
   localparam logic [OP_W-1:0] OP_SLL    = 4'd7;
   localparam logic [OP_W-1:0] OP_SRL    = 4'd8;
   localparam logic [OP_W-1:0] OP_SRA    = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SH_NONE = 2'd0,
      SH_SLL  = 2'd1,
      SH_SRL  = 2'd2,
      SH_SRA  = 2'd3
   } shift_t;

   // Classifies an opcode as one of the iterated shifts, or SH_NONE for everything else.
   function automatic shift_t shift_type(input logic [OP_W-1:0] op);
      case (op)
         OP_SLL:  return SH_SLL;
         OP_SRL:  return SH_SRL;
         OP_SRA:  return SH_SRA;
         default: return SH_NONE;
      endcase
   endfunction

endpackage

// File: rtl/alu_gates.sv
// Bitwise gate-level op modules used by the logic core.
// Latency: combinational.
// Backpressure: none (pure functions of a/b).
// Ports: a, b (WIDTH operands, where used), y (WIDTH result).

module _OR #(parameter int WIDTH = 8) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);
   assign y = a | b;
endmodule

module _AND #(parameter int WIDTH = 8) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);
   assign y = a & b;
endmodule

module _XOR #(parameter int WIDTH = 8) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);
   assign y = a ^ b;
endmodule

module _NOR #(parameter int WIDTH = 8) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);
   assign y = ~(a | b);
endmodule

module _NOT_A #(parameter int WIDTH = 8) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);
   assign y = ~a;
endmodule

module _OUTPUT_A #(parameter int WIDTH = 8) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);
   assign y = a;
endmodule

module _OUTPUT_B #(parameter int WIDTH = 8) (
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);
   assign y = b;
endmodule

// File: rtl/alu_logic_core.sv
// Single-cycle logic ops: selects one gate module output by opcode and flags unsupported opcodes.
// Latency: combinational.
// Backpressure: none; the caller registers the result.
// Ports: op (opcode), a, b (operands), result (logic result, 0 for shifts/illegal), illegal (opcode 10-15).
module alu_logic_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             illegal
);

   logic [WIDTH-1:0] or_y, and_y, xor_y, nor_y, nota_y, pa_y, pb_y;

   _OR       #(.WIDTH(WIDTH)) u_or   (.a(a), .b(b), .y(or_y));
   _AND      #(.WIDTH(WIDTH)) u_and  (.a(a), .b(b), .y(and_y));
   _XOR      #(.WIDTH(WIDTH)) u_xor  (.a(a), .b(b), .y(xor_y));
   _NOR      #(.WIDTH(WIDTH)) u_nor  (.a(a), .b(b), .y(nor_y));
   _NOT_A    #(.WIDTH(WIDTH)) u_nota (.a(a), .y(nota_y));
   _OUTPUT_A #(.WIDTH(WIDTH)) u_pa   (.a(a), .y(pa_y));
   _OUTPUT_B #(.WIDTH(WIDTH)) u_pb   (.b(b), .y(pb_y));

   always_comb begin
      result  = '0;
      illegal = 1'b0;
      case (op)
         OP_OR:     result = or_y;
         OP_AND:    result = and_y;
         OP_XOR:    result = xor_y;
         OP_NOR:    result = nor_y;
         OP_NOT_A:  result = nota_y;
         OP_PASS_A: result = pa_y;
         OP_PASS_B: result = pb_y;
         // Shifts are iterated by the sequencer; nothing to produce here.
         OP_SLL, OP_SRL, OP_SRA: result = '0;
         // Illegal opcodes report a zero result so the zero flag comes out set.
         default:   illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Handshaked ALU front end: logic ops in one cycle, shifts iterated one bit per cycle.
// Latency: 1 cycle for logic/illegal ops and zero-amount shifts, 1+n cycles for a shift by n.
// Backpressure: in_ready only in IDLE; result and flags held stable in DONE until out_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_op/in_a/in_b operand channel;
//        out_valid/out_ready/out_result/out_zero/out_illegal result channel.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_illegal
);

   localparam int SHW = $clog2(WIDTH);

   state_t           state_q, state_nxt;
   shift_t           shop_q, shop_nxt;
   logic [WIDTH-1:0] acc_q, acc_nxt;
   logic [SHW-1:0]   cnt_q, cnt_nxt;
   logic [WIDTH-1:0] res_q, res_nxt;
   logic             zero_q, zero_nxt;
   logic             ill_q, ill_nxt;

   logic [WIDTH-1:0] core_result;
   logic             core_illegal;
   logic [WIDTH-1:0] acc_sh;
   shift_t           in_sht;
   logic [SHW-1:0]   in_shamt;
   logic             accept;

   // One-bit shift step; SRA replicates the sign bit of the accumulator.
   function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input shift_t t);
      case (t)
         SH_SLL:  return {v[WIDTH-2:0], 1'b0};
         SH_SRL:  return {1'b0, v[WIDTH-1:1]};
         SH_SRA:  return {v[WIDTH-1], v[WIDTH-1:1]};
         default: return v;
      endcase
   endfunction

   alu_logic_core #(.WIDTH(WIDTH)) u_core (
      .op      (in_op),
      .a       (in_a),
      .b       (in_b),
      .result  (core_result),
      .illegal (core_illegal)
   );

   assign in_ready    = (state_q == ST_IDLE) && !rst;
   assign accept      = in_valid && in_ready;
   assign out_valid   = (state_q == ST_DONE);
   assign out_result  = res_q;
   assign out_zero    = zero_q;
   assign out_illegal = ill_q;

   assign in_sht   = shift_type(in_op);
   assign in_shamt = in_b[SHW-1:0];
   assign acc_sh   = shift1(acc_q, shop_q);

   always_comb begin
      state_nxt = state_q;
      shop_nxt  = shop_q;
      acc_nxt   = acc_q;
      cnt_nxt   = cnt_q;
      res_nxt   = res_q;
      zero_nxt  = zero_q;
      ill_nxt   = ill_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (in_sht != SH_NONE && in_shamt != '0) begin
                  acc_nxt   = in_a;
                  cnt_nxt   = in_shamt;
                  shop_nxt  = in_sht;
                  state_nxt = ST_SHIFT;
               end else if (in_sht != SH_NONE) begin
                  // Shift by zero finishes immediately with A unchanged.
                  res_nxt   = in_a;
                  zero_nxt  = (in_a == '0);
                  ill_nxt   = 1'b0;
                  state_nxt = ST_DONE;
               end else begin
                  res_nxt   = core_result;
                  zero_nxt  = (core_result == '0);
                  ill_nxt   = core_illegal;
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_SHIFT: begin
            acc_nxt = acc_sh;
            cnt_nxt = cnt_q - 1'b1;
            if (cnt_q == SHW'(1)) begin
               res_nxt   = acc_sh;
               zero_nxt  = (acc_sh == '0);
               ill_nxt   = 1'b0;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         shop_q  <= SH_NONE;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         shop_q  <= shop_nxt;
         acc_q   <= acc_nxt;
         cnt_q   <= cnt_nxt;
         res_q   <= res_nxt;
         zero_q  <= zero_nxt;
         ill_q   <= ill_nxt;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer at WIDTH=8: directed vector table, reset abort, random ops.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low for a per-vector number of cycles.
module tb_alu_op_sequencer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   in_op;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_result;
   logic         out_zero;
   logic         out_illegal;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_a        (in_a),
      .in_b        (in_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_zero    (out_zero),
      .out_illegal (out_illegal)
   );

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           hold;
      logic [W-1:0] res;
      logic         zero;
      logic         ill;
      int           lat;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference behaviour straight from the opcode table.
   function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic z, output logic ill, output int lat);
      int sh;
      sh  = int'(b % W);
      ill = 1'b0;
      lat = 1;
      case (op)
         4'd0: r = a | b;
         4'd1: r = a & b;
         4'd2: r = a ^ b;
         4'd3: r = ~(a | b);
         4'd4: r = ~a;
         4'd5: r = a;
         4'd6: r = b;
         4'd7: begin r = a << sh;                lat = 1 + sh; end
         4'd8: begin r = a >> sh;                lat = 1 + sh; end
         4'd9: begin r = W'($signed(a) >>> sh);  lat = 1 + sh; end
         default: begin r = '0; ill = 1'b1; end
      endcase
      z = (r == '0);
   endfunction

   task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold, input logic [W-1:0] er,
                        input logic ez, input logic ei, input int elat);
      int n;
      int lat;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, " ready_before"}, 32'(in_ready), 32'd1);
      in_op     = op;
      in_a      = a;
      in_b      = b;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      // Keep offering a different beat while busy; it must be ignored.
      in_op = 4'($urandom);
      in_a  = W'($urandom);
      in_b  = W'($urandom);
      lat   = 1;
      while (!out_valid && lat < 40) begin
         check({tag, " busy_ready"}, 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         lat++;
         in_a = W'($urandom);
      end
      check({tag, " latency"}, 32'(lat), 32'(elat));
      check({tag, " result"}, 32'(out_result), 32'(er));
      check({tag, " zero"}, 32'(out_zero), 32'(ez));
      check({tag, " illegal"}, 32'(out_illegal), 32'(ei));
      check({tag, " done_ready"}, 32'(in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, " hold_result"}, {out_zero, out_illegal, 22'd0, out_result}, {ez, ei, 22'd0, er});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, " valid_dropped"}, 32'(out_valid), 32'd0);
      check({tag, " ready_after"}, 32'(in_ready), 32'd1);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] r;
      logic         z;
      logic         il;
      int           lt;
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           hold;

      vecs[0]  = '{4'd0,  8'hA5, 8'h0F, 0, 8'hAF, 1'b0, 1'b0, 1};
      vecs[1]  = '{4'd7,  8'h81, 8'h03, 0, 8'h08, 1'b0, 1'b0, 4};
      vecs[2]  = '{4'd9,  8'h90, 8'h02, 0, 8'hE4, 1'b0, 1'b0, 3};
      vecs[3]  = '{4'd8,  8'h90, 8'h02, 0, 8'h24, 1'b0, 1'b0, 3};
      vecs[4]  = '{4'd7,  8'h55, 8'hF8, 0, 8'h55, 1'b0, 1'b0, 1};
      vecs[5]  = '{4'd3,  8'hFF, 8'h00, 5, 8'h00, 1'b1, 1'b0, 1};
      vecs[6]  = '{4'hC,  8'h12, 8'h34, 0, 8'h00, 1'b1, 1'b1, 1};
      vecs[7]  = '{4'd1,  8'hF0, 8'h3C, 0, 8'h30, 1'b0, 1'b0, 1};
      vecs[8]  = '{4'd2,  8'hFF, 8'h0F, 1, 8'hF0, 1'b0, 1'b0, 1};
      vecs[9]  = '{4'd4,  8'h0F, 8'hAA, 0, 8'hF0, 1'b0, 1'b0, 1};
      vecs[10] = '{4'd5,  8'h5A, 8'h11, 0, 8'h5A, 1'b0, 1'b0, 1};
      vecs[11] = '{4'd6,  8'h00, 8'hC3, 2, 8'hC3, 1'b0, 1'b0, 1};
      vecs[12] = '{4'd9,  8'h7F, 8'h07, 0, 8'h00, 1'b1, 1'b0, 8};
      vecs[13] = '{4'd7,  8'h01, 8'h0F, 3, 8'h80, 1'b0, 1'b0, 8};
      vecs[14] = '{4'hF,  8'hFF, 8'hFF, 0, 8'h00, 1'b1, 1'b1, 1};
      vecs[15] = '{4'd2,  8'hAA, 8'hAA, 0, 8'h00, 1'b1, 1'b0, 1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_op     = '0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      check("reset in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset flags/result", {out_zero, out_illegal, 22'd0, out_result}, 32'd0);
      rst = 1'b0;
      #1;
      check("post-reset in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 16; i++)
         do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold,
               vecs[i].res, vecs[i].zero, vecs[i].ill, vecs[i].lat);

      // Reset in the third cycle of an SLL by 7: the result must never appear.
      in_op     = 4'd7;
      in_a      = 8'h01;
      in_b      = 8'h07;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("abort rst in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("abort in_ready", 32'(in_ready), 32'd1);
      check("abort out_valid", 32'(out_valid), 32'd0);
      check("abort out_result", 32'(out_result), 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("abort no result", 32'(out_valid), 32'd0);
      end
      out_ready = 1'b0;
      do_op("after_abort", 4'd8, 8'hF0, 8'h04, 0, 8'h0F, 1'b0, 1'b0, 5);

      for (int i = 0; i < 150; i++) begin
         op   = 4'($urandom_range(0, 15));
         a    = W'($urandom);
         b    = W'($urandom);
         hold = $urandom_range(0, 2);
         model(op, a, b, r, z, il, lt);
         do_op($sformatf("rnd%0d op%0d", i, op), op, a, b, hold, r, z, il, lt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
